// File: rtl/alu_ctrl_unit.sv
// Instruction sequencer and 4-entry register file feeding an external combinational ALU.
// Issues one instruction at a time: fetch operands, capture the ALU result, then hand it back over valid/ready.
module alu_ctrl_unit #(
  parameter int DATA_W = 4,
  parameter int REG_AW = 2,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3+3*REG_AW-1:0] in_instr,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [2:0]            alu_op,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zf,
  input  logic                  alu_sf,
  input  logic                  alu_of,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [2:0]            out_flags,
  input  logic [REG_AW-1:0]     dbg_sel,
  output logic [DATA_W-1:0]     dbg_data,
  output logic [CNT_W-1:0]      instr_cnt
);

  // state | meaning
  // IDLE  | waiting for an instruction, in_ready high
  // EXEC  | operands and op presented to the ALU, result captured at the closing edge
  // RESP  | result and flags held until the consumer takes them

  localparam int IW = 3 + 3*REG_AW;
  localparam int NREG = 1 << REG_AW;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state;
  logic [DATA_W-1:0]     rf [NREG];
  logic [REG_AW-1:0]     rd_q;
  logic [2*REG_AW-1:0]   imm_q;
  logic [DATA_W-1:0]     ldi_val;

  logic [2:0]            op_in;
  logic [REG_AW-1:0]     rd_in;
  logic [REG_AW-1:0]     rs1_in;
  logic [REG_AW-1:0]     rs2_in;

  assign op_in  = in_instr[IW-1 -: 3];
  assign rd_in  = in_instr[3*REG_AW-1 -: REG_AW];
  assign rs1_in = in_instr[2*REG_AW-1 -: REG_AW];
  assign rs2_in = in_instr[REG_AW-1:0];

  // LDI immediate is the {rs1,rs2} field, zero-extended (or truncated) to the data width
  assign ldi_val  = DATA_W'(imm_q);
  assign in_ready = (state == IDLE);
  assign dbg_data = rf[dbg_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
      instr_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            rd_q   <= rd_in;
            imm_q  <= {rs1_in, rs2_in};
            alu_a  <= rf[rs1_in];
            alu_b  <= rf[rs2_in];
            alu_op <= op_in;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // operands were captured in IDLE, so rs==rd reads see the old value
          if (alu_op == OP_LDI) begin
            rf[rd_q] <= ldi_val;
            out_data <= ldi_val;
          end else begin
            rf[rd_q]  <= alu_result;
            out_data  <= alu_result;
            out_flags <= {alu_zf, alu_sf, alu_of};
          end
          out_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            instr_cnt <= instr_cnt + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed bench for alu_ctrl_unit with a behavioural 4-bit ALU in the loop.
// Drives and samples on the falling edge; each scenario task checks its own results.
module tb_alu_ctrl_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_zf, alu_sf, alu_of;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
  logic [2:0] out_flags;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;
  logic [7:0] instr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] last_data, exec_a, exec_b;
  logic [2:0] last_flags, exec_op;
  logic       exec_ov, exec_ir;
  int         lat;

  alu_ctrl_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, otherwise pass A
  always_comb begin
    alu_result = alu_a;
    alu_of     = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_result = alu_a + alu_b;
        alu_of = (alu_a[3] == alu_b[3]) && (alu_result[3] != alu_a[3]);
      end
      3'b001: begin
        alu_result = alu_a - alu_b;
        alu_of = (alu_a[3] != alu_b[3]) && (alu_result[3] != alu_a[3]);
      end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      default: alu_result = alu_a;
    endcase
    alu_zf = (alu_result == 4'd0);
    alu_sf = alu_result[3];
  end

  // Issue one instruction; if take is set, also complete the response handshake
  task automatic exec_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                            input logic [1:0] rs2, input bit take);
    int n;
    n = 0;
    while (!in_ready && n < 10) begin @(negedge clk); n++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL issue_wait: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    in_instr  = {op, rd, rs1, rs2};
    in_valid  = 1'b1;
    out_ready = take;
    @(negedge clk);
    in_valid = 1'b0;
    exec_a  = alu_a;
    exec_b  = alu_b;
    exec_op = alu_op;
    exec_ov = out_valid;
    exec_ir = in_ready;
    lat = 1;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    if (!out_valid) begin
      n_tests++; n_fail++;
      $display("FAIL resp_wait: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
    last_data  = out_data;
    last_flags = out_flags;
    if (take) begin
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; dbg_sel = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_tests++; if (instr_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", instr_cnt); end
    n_tests++; if ({alu_a, alu_b, alu_op} !== 11'd0) begin n_fail++; $display("FAIL rst_alu: got %0h/%0h/%0h want 0", alu_a, alu_b, alu_op); end
    n_tests++; if ({out_data, out_flags} !== 7'd0) begin n_fail++; $display("FAIL rst_out: got %0h/%0b want 0", out_data, out_flags); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    exec_instr(3'b111, 2'd0, 2'd0, 2'd3, 1'b1);
    n_tests++; if (last_data !== 4'd3) begin n_fail++; $display("FAIL ldi_r0: got %0h want 3", last_data); end
    exec_instr(3'b111, 2'd1, 2'd1, 2'd0, 1'b1);
    exec_instr(3'b000, 2'd2, 2'd0, 2'd1, 1'b1);
    n_tests++; if (last_data !== 4'd7) begin n_fail++; $display("FAIL add_data: got %0h want 7", last_data); end
    n_tests++; if (last_flags !== 3'b000) begin n_fail++; $display("FAIL add_flags: got %03b want 000", last_flags); end
    dbg_sel = 2'd2; #1;
    n_tests++; if (dbg_data !== 4'd7) begin n_fail++; $display("FAIL add_dbg: got %0h want 7", dbg_data); end
    n_tests++; if (instr_cnt !== 8'd3) begin n_fail++; $display("FAIL add_cnt: got %0d want 3", instr_cnt); end
  endtask

  task automatic test_overflow_ldi();
    exec_instr(3'b111, 2'd0, 2'd1, 2'd3, 1'b1);
    exec_instr(3'b111, 2'd1, 2'd1, 2'd3, 1'b1);
    exec_instr(3'b000, 2'd2, 2'd0, 2'd1, 1'b1);
    n_tests++; if (last_data !== 4'b1110) begin n_fail++; $display("FAIL ovf_data: got %0h want e", last_data); end
    n_tests++; if (last_flags !== 3'b011) begin n_fail++; $display("FAIL ovf_flags: got %03b want 011", last_flags); end
    exec_instr(3'b111, 2'd3, 2'd1, 2'd1, 1'b1);
    n_tests++; if (last_data !== 4'd5) begin n_fail++; $display("FAIL ldi_r3: got %0h want 5", last_data); end
    n_tests++; if (last_flags !== 3'b011) begin n_fail++; $display("FAIL ldi_keeps_flags: got %03b want 011", last_flags); end
  endtask

  task automatic test_sub_self();
    exec_instr(3'b111, 2'd0, 2'd0, 2'd3, 1'b1);
    exec_instr(3'b001, 2'd1, 2'd0, 2'd0, 1'b1);
    n_tests++; if (last_data !== 4'd0) begin n_fail++; $display("FAIL sub_data: got %0h want 0", last_data); end
    n_tests++; if (last_flags !== 3'b100) begin n_fail++; $display("FAIL sub_flags: got %03b want 100", last_flags); end
    exec_instr(3'b001, 2'd0, 2'd0, 2'd0, 1'b1);
    n_tests++; if ({exec_a, exec_b} !== 8'h33) begin n_fail++; $display("FAIL sub_self_read: got %0h/%0h want 3/3", exec_a, exec_b); end
    dbg_sel = 2'd0; #1;
    n_tests++; if (dbg_data !== 4'd0) begin n_fail++; $display("FAIL sub_self_wb: got %0h want 0", dbg_data); end
    n_tests++; if (instr_cnt !== 8'd10) begin n_fail++; $display("FAIL sub_cnt: got %0d want 10", instr_cnt); end
  endtask

  task automatic test_backpressure();
    exec_instr(3'b111, 2'd1, 2'd2, 2'd1, 1'b0);
    in_instr = {3'b111, 2'd2, 2'd3, 2'd3};
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 4'd9 || out_flags !== 3'b100 || in_ready !== 1'b0 || instr_cnt !== 8'd10) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: valid=%0b data=%0h flags=%03b ready=%0b cnt=%0d want 1/9/100/0/10",
                 i, out_valid, out_data, out_flags, in_ready, instr_cnt);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid: got %0b want 0", out_valid); end
    n_tests++; if (instr_cnt !== 8'd11) begin n_fail++; $display("FAIL hold_release_cnt: got %0d want 11", instr_cnt); end
    dbg_sel = 2'd2; #1;
    n_tests++; if (dbg_data !== 4'he) begin n_fail++; $display("FAIL ignored_instr_r2: got %0h want e", dbg_data); end
    @(negedge clk);
    n_tests++; if (instr_cnt !== 8'd11) begin n_fail++; $display("FAIL single_handshake: got %0d want 11", instr_cnt); end
  endtask

  task automatic test_latency();
    exec_instr(3'b000, 2'd3, 2'd1, 2'd1, 1'b1);
    n_tests++; if (exec_op !== 3'b000 || exec_a !== 4'd9) begin n_fail++; $display("FAIL lat_exec_regs: op=%0b a=%0h want 000/9", exec_op, exec_a); end
    n_tests++; if (exec_ov !== 1'b0 || exec_ir !== 1'b0) begin n_fail++; $display("FAIL lat_exec_handshake: valid=%0b ready=%0b want 0/0", exec_ov, exec_ir); end
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL lat_edges: got %0d want 2", lat); end
    n_tests++; if (last_data !== 4'd2 || last_flags !== 3'b001) begin n_fail++; $display("FAIL lat_result: got %0h/%03b want 2/001", last_data, last_flags); end
  endtask

  task automatic test_reset_mid_exec();
    in_instr = {3'b001, 2'd3, 2'd1, 2'd0};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (alu_op !== 3'b001 || alu_a !== 4'd9) begin n_fail++; $display("FAIL mid_exec_pre: op=%0b a=%0h want 001/9", alu_op, alu_a); end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({alu_a, alu_b, alu_op} !== 11'd0 || out_valid !== 1'b0 || out_data !== 4'd0 || out_flags !== 3'd0 ||
        instr_cnt !== 8'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_rst: a=%0h b=%0h op=%0h v=%0b d=%0h f=%0b cnt=%0d rdy=%0b want all 0, rdy 1",
               alu_a, alu_b, alu_op, out_valid, out_data, out_flags, instr_cnt, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_tests++; if (dbg_data !== 4'd0) begin n_fail++; $display("FAIL rst_rf%0d: got %0h want 0", i, dbg_data); end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exec_instr(3'b111, 2'd0, 2'd0, 2'd2, 1'b1);
    n_tests++; if (last_data !== 4'd2 || instr_cnt !== 8'd1) begin n_fail++; $display("FAIL post_rst: data=%0h cnt=%0d want 2/1", last_data, instr_cnt); end
    dbg_sel = 2'd3; #1;
    n_tests++; if (dbg_data !== 4'd0) begin n_fail++; $display("FAIL dropped_instr: r3=%0h want 0", dbg_data); end
  endtask

  task automatic test_cnt_wrap();
    for (int i = 0; i < 254; i++) exec_instr(3'b111, 2'd1, 2'd0, 2'd1, 1'b1);
    n_tests++; if (instr_cnt !== 8'd255) begin n_fail++; $display("FAIL cnt_max: got %0d want 255", instr_cnt); end
    exec_instr(3'b111, 2'd1, 2'd0, 2'd1, 1'b1);
    n_tests++; if (instr_cnt !== 8'd0) begin n_fail++; $display("FAIL cnt_wrap: got %0d want 0", instr_cnt); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow_ldi();
    test_sub_self();
    test_backpressure();
    test_latency();
    test_reset_mid_exec();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
